uart_loader: RTL and testbench
==============================

Name: uart_loader

Overview:
- Packet-level consumer on the RX side of the UART wrapper; sits between the wrapper's byte FIFOs and the system memory bus.
- Pops received bytes, parses framed write packets (sync, address, length, data words, checksum) and issues 32-bit memory writes.
- Returns a one-byte ACK/NAK through the wrapper's TX FIFO.
- Used for boot-time program loading over serial.

Parameters:
- ADDR_W, 32, memory address width; the packet carries 4 address bytes, truncated to ADDR_W.
- SYNC_BYTE, 8'hA5, packet start marker.

Ports:
- clk_i  in  1  single system clock
- rst_i  in  1  synchronous, active-high reset
- uart_status_i  in  8  wrapper status {4'b0, RXempty, RXfull, TXempty, TXfull}
- uart_data_i  in  8  RX FIFO head byte; valid the cycle after uart_read_o
- uart_read_o  out  1  one-cycle RX FIFO pop strobe
- uart_data_o  out  8  response byte to TX FIFO
- uart_write_o  out  1  one-cycle TX FIFO push strobe
- mem_addr_o  out  ADDR_W  word write address
- mem_data_o  out  32  write data
- mem_we_o  out  1  write request; held until mem_ready_i
- mem_ready_i  in  1  write accepted this cycle
- busy_o  out  1  high from sync-byte accept until the response is pushed
- done_o  out  1  one-cycle pulse with each response; err_o valid on this pulse
- err_o  out  1  1 = last packet NAKed

Behaviour:
- Reset: all outputs 0; state HUNT; checksum, byte count and word count cleared. Reset mid-packet abandons the packet; no response is sent.
- Packet format: SYNC, A0..A3 (little-endian), LEN (words, 1..255), LEN×4 data bytes (little-endian per word), CSUM.
- Checksum rule: the 8-bit sum of A0..CSUM must be 0.
- Byte fetch:
  - Cycle N: uart_read_o=1 only if RXempty (bit 3)=0.
  - Cycle N+1: uart_data_i is captured.
  - At most one pop per two cycles; never pop while RXempty=1.
- States and transitions:
  - HUNT: fetch bytes and discard until SYNC_BYTE is seen → ADDR. busy_o rises on the capture cycle.
  - ADDR: 4 bytes, address register built little-endian → LEN.
  - LEN:
    - LEN=0 → set NAK flag and go to RESP. No memory writes; the rest of the stream is resynchronised by HUNT.
    - LEN>0 → DATA.
  - DATA: assemble 4 bytes → MEMWR.
  - MEMWR:
    - Assert mem_we_o with address and data stable until mem_ready_i. mem_ready_i may already be high in the first cycle (single-cycle write).
    - On acceptance: address += 4 (wraps modulo 2^ADDR_W); words_left−1.
    - words_left≠0 → DATA; else → CSUM.
  - CSUM: fetch the checksum byte; nonzero total sum → NAK flag → RESP.
  - RESP:
    - Wait while TXfull (bit 0)=1; then one-cycle uart_write_o with 8'h06 (ACK) or 8'h15 (NAK).
    - Same cycle: done_o=1, err_o=NAK flag, busy_o→0; next state HUNT.
- Data words are written as they complete. A checksum failure NAKs but does not roll back writes; the host retransmits.
- A SYNC_BYTE value inside the payload is treated as data; there is no in-packet resync.
- Simultaneous events: mem_ready_i is ignored outside MEMWR; RX bytes arriving during MEMWR/RESP stay queued in the FIFO.

Optional Feature:
- Macro UART_LOADER_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYC (default 1_000_000) and a counter, cleared on every byte capture and on entry to HUNT.
  - In any byte-fetch state other than HUNT, when the counter reaches TIMEOUT_CYC: NAK via RESP (err_o=1) → HUNT.
- Undefined: no counter; the loader waits indefinitely for bytes.

Decomposition:
- Package uart_loader_pkg:
  - state enum (HUNT, ADDR, LEN, DATA, MEMWR, CSUM, RESP)
  - constants ACK_BYTE=8'h06, NAK_BYTE=8'h15
  - status bit indices RX_EMPTY_BIT=3, TX_FULL_BIT=0
- Sub-module uart_byte_reader:
  - Handles the pop/capture handshake.
  - Interface: req_i; byte_o/valid_o, with a one-cycle valid_o pulse per byte.
  - The top FSM consumes only valid_o.

Test Plan:
- Nominal: A5 00 10 00 00 01 EF BE AD DE, checksum making the sum zero → one write addr 0x00001000 data 0xDEADBEEF; TX byte 0x06; done_o=1, err_o=0.
- Multi-word with mem_ready_i stalled 3 cycles per word; LEN=3 → writes at 0x100, 0x104, 0x108; mem_addr_o/mem_data_o stable during each stall; ACK.
- Bad checksum (CSUM+1) → writes still occur; TX 0x15, err_o=1; an immediately following good packet → ACK.
- Leading garbage 00 FF 5A then a valid packet → garbage discarded, single ACK; LEN=0 packet → NAK with no mem_we_o.
- Back-pressure:
  - RXempty toggled per byte → uart_read_o never asserted while RXempty=1.
  - TXfull=1 for 10 cycles in RESP → uart_write_o held off, then a single push.
- rst_i asserted during DATA → all outputs 0 next cycle, no response; the next packet parses normally. With UART_LOADER_TIMEOUT_EN: stream stops after A1 → NAK after TIMEOUT_CYC cycles.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the serial boot loader: FSM state codes,
// response bytes and the bit positions in the UART wrapper status word.
package uart_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_HUNT  = 3'd0;
    localparam state_t ST_ADDR  = 3'd1;
    localparam state_t ST_LEN   = 3'd2;
    localparam state_t ST_DATA  = 3'd3;
    localparam state_t ST_MEMWR = 3'd4;
    localparam state_t ST_CSUM  = 3'd5;
    localparam state_t ST_RESP  = 3'd6;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam int RX_EMPTY_BIT = 3;
    localparam int TX_FULL_BIT  = 0;

    // States in which the loader wants the next RX byte.
    function automatic logic is_fetch_state(input state_t s);
        return (s == ST_HUNT) || (s == ST_ADDR) || (s == ST_LEN) ||
               (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/uart_loader_byte_reader.sv
// RX FIFO pop/capture handshake: pop in cycle N, byte presented with a
// one-cycle valid pulse in cycle N+1. Never more than one pop per two cycles.
module uart_byte_reader (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic       rx_empty_i,
    input  logic [7:0] data_i,
    output logic       rd_o,
    output logic [7:0] byte_o,
    output logic       valid_o
);

    logic r_wait;
    logic w_rd;

    // r_wait marks the capture cycle, which also blocks a back-to-back pop.
    assign w_rd = req_i && !rx_empty_i && !r_wait && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait <= 1'b0;
        end else begin
            r_wait <= w_rd;
        end
    end

    assign rd_o    = w_rd;
    assign valid_o = r_wait;
    assign byte_o  = data_i;

endmodule

// File: rtl/uart_loader.sv
// Serial packet loader: SYNC, A0..A3, LEN, LEN*4 data bytes, CSUM -> 32-bit
// memory writes plus an ACK/NAK byte. Optional byte timeout: UART_LOADER_TIMEOUT_EN.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
`ifdef UART_LOADER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        uart_status_i,
    input  logic [7:0]        uart_data_i,
    output logic              uart_read_o,
    output logic [7:0]        uart_data_o,
    output logic              uart_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              mem_we_o,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        dbg_state_o
);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_word;
    logic [1:0]  r_cnt;
    logic [7:0]  r_words_left;
    logic [7:0]  r_csum;
    logic        r_nak;

    logic        w_req;
    logic        w_rd;
    logic        w_valid;
    logic [7:0]  w_byte;
    logic [7:0]  w_sum;
    logic        w_push;
    logic        w_sync_hit;
    logic        w_timeout;
    logic        w_unused_status;

    assign w_unused_status = ^{uart_status_i[7:4], uart_status_i[2:1]};

    assign w_req = is_fetch_state(r_state);

    uart_byte_reader u_reader (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (w_req),
        .rx_empty_i (uart_status_i[RX_EMPTY_BIT]),
        .data_i     (uart_data_i),
        .rd_o       (w_rd),
        .byte_o     (w_byte),
        .valid_o    (w_valid)
    );

    assign w_sum      = r_csum + w_byte;
    assign w_push     = (r_state == ST_RESP) && !uart_status_i[TX_FULL_BIT];
    assign w_sync_hit = (r_state == ST_HUNT) && w_valid && (w_byte == SYNC_BYTE);

`ifdef UART_LOADER_TIMEOUT_EN
    logic [31:0] r_tmo;

    // A pop or capture in flight defers the timeout so no fetched byte is lost.
    assign w_timeout = w_req && (r_state != ST_HUNT) && !w_rd && !w_valid &&
                       (r_tmo == 32'(TIMEOUT_CYC));

    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state == ST_HUNT) || w_valid) begin
            r_tmo <= '0;
        end else if (w_req && (r_tmo != 32'(TIMEOUT_CYC))) begin
            r_tmo <= r_tmo + 32'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_HUNT;
            r_addr       <= '0;
            r_word       <= '0;
            r_cnt        <= '0;
            r_words_left <= '0;
            r_csum       <= '0;
            r_nak        <= 1'b0;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    if (w_sync_hit) begin
                        r_state <= ST_ADDR;
                        r_cnt   <= '0;
                        r_csum  <= '0;
                        r_nak   <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (w_valid) begin
                        r_addr[{r_cnt, 3'b000} +: 8] <= w_byte;
                        r_csum <= w_sum;
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= ST_LEN;
                        end
                    end
                end
                ST_LEN: begin
                    if (w_valid) begin
                        r_csum       <= w_sum;
                        r_words_left <= w_byte;
                        r_cnt        <= '0;
                        // Zero length is malformed; leftover bytes fall to HUNT.
                        if (w_byte == 8'd0) begin
                            r_nak   <= 1'b1;
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_valid) begin
                        r_word[{r_cnt, 3'b000} +: 8] <= w_byte;
                        r_csum <= w_sum;
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= ST_MEMWR;
                        end
                    end
                end
                ST_MEMWR: begin
                    if (mem_ready_i) begin
                        r_addr       <= r_addr + 32'd4;
                        r_words_left <= r_words_left - 8'd1;
                        r_state      <= (r_words_left == 8'd1) ? ST_CSUM : ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (w_valid) begin
                        r_nak   <= (w_sum != 8'd0);
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_push) begin
                        r_state <= ST_HUNT;
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
            if (w_timeout) begin
                r_nak   <= 1'b1;
                r_state <= ST_RESP;
            end
        end
    end

    assign uart_read_o  = w_rd;
    assign uart_write_o = w_push;
    assign uart_data_o  = w_push ? (r_nak ? NAK_BYTE : ACK_BYTE) : 8'h00;
    assign done_o       = w_push;
    assign err_o        = w_push && r_nak;
    // Rises with the sync capture and drops with the response push.
    assign busy_o       = w_sync_hit ||
                          ((r_state != ST_HUNT) && !w_push);
    assign mem_we_o     = (r_state == ST_MEMWR);
    assign mem_addr_o   = r_addr[ADDR_W-1:0];
    assign mem_data_o   = r_word;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: RX FIFO and memory/TX models, write and
// response scoreboards, one summary line. Timeout case with UART_LOADER_TIMEOUT_EN.
module tb_uart_loader;
    import uart_loader_pkg::*;

    localparam int TMO = 200;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  uart_status_i;
    logic [7:0]  uart_data_i;
    logic        uart_read_o;
    logic [7:0]  uart_data_o;
    logic        uart_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_we_o;
    logic        mem_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [2:0]  dbg_state_o;

`ifdef UART_LOADER_TIMEOUT_EN
    uart_loader #(.TIMEOUT_CYC(TMO)) dut (
`else
    uart_loader dut (
`endif
        .clk_i         (clk),
        .rst_i         (rst),
        .uart_status_i (uart_status_i),
        .uart_data_i   (uart_data_i),
        .uart_read_o   (uart_read_o),
        .uart_data_o   (uart_data_o),
        .uart_write_o  (uart_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_we_o      (mem_we_o),
        .mem_ready_i   (mem_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .dbg_state_o   (dbg_state_o)
    );

    // scoreboard state
    int n_vec  = 0;
    int n_miss = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  exp_tx_q[$];
    int tx_cnt = 0;
    int we_acc = 0;
    int rd_viol = 0;
    int stable_err = 0;
    int pulse_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RX FIFO model
    logic [7:0] rx_mem [0:1023];
    int   rx_wp = 0;
    int   rx_rp = 0;
    logic rx_hold = 1'b0;
    logic rx_tog = 1'b0;
    logic tx_full = 1'b0;

    assign uart_status_i = {4'b0000, (rx_wp == rx_rp) || rx_hold, 1'b0, 1'b1, tx_full};

    always @(posedge clk) begin
        if (uart_read_o) begin
            uart_data_i <= rx_mem[rx_rp % 1024];
            rx_rp       <= rx_rp + 1;
        end
    end

    always @(posedge clk) begin
        #2;
        rx_hold = rx_tog ? ~rx_hold : 1'b0;
    end

    // memory ready model with configurable stall
    int mem_stall = 0;
    int wait_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (mem_we_o) begin
            if (wait_cnt >= mem_stall) begin
                mem_ready_i = 1'b1;
            end else begin
                mem_ready_i = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ready_i = 1'b0;
            wait_cnt = 0;
        end
    end

    // monitors, sampled on the falling edge
    logic        we_prev = 1'b0;
    logic [31:0] lat_a, lat_d;
    always @(negedge clk) begin
        if (uart_read_o && uart_status_i[RX_EMPTY_BIT]) rd_viol++;
        if (done_o !== uart_write_o) pulse_err++;
        if (mem_we_o) begin
            if (!we_prev) begin
                lat_a = mem_addr_o;
                lat_d = mem_data_o;
            end else if (mem_addr_o !== lat_a || mem_data_o !== lat_d) begin
                stable_err++;
            end
            if (mem_ready_i) begin
                logic [63:0] e;
                we_acc++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hxxxx_xxxx_xxxx_xxxx;
                check_eq("mem_write", {mem_addr_o, mem_data_o}, e);
            end
        end
        we_prev = mem_we_o;
        if (uart_write_o) begin
            logic [7:0] et;
            tx_cnt++;
            et = (exp_tx_q.size() > 0) ? exp_tx_q.pop_front() : 8'hxx;
            check_eq("tx_byte", 64'(uart_data_o), 64'(et));
            check_eq("err_o", 64'(err_o), 64'(et == NAK_BYTE));
        end
    end

    // driver tasks
    task automatic push_byte(input logic [7:0] b);
        rx_mem[rx_wp % 1024] = b;
        rx_wp++;
    endtask

    // Data words are base + i*04040404; checksum makes A0..CSUM sum to zero.
    task automatic push_pkt(input logic [31:0] addr, input int n, input logic [31:0] base,
                            input logic bad);
        logic [7:0]  s;
        logic [31:0] w;
        s = 8'h00;
        push_byte(8'hA5);
        for (int i = 0; i < 4; i++) begin
            push_byte(addr[8*i +: 8]);
            s = s + addr[8*i +: 8];
        end
        push_byte(8'(n));
        s = s + 8'(n);
        for (int k = 0; k < n; k++) begin
            w = base + 32'(k) * 32'h0404_0404;
            for (int i = 0; i < 4; i++) begin
                push_byte(w[8*i +: 8]);
                s = s + w[8*i +: 8];
            end
            exp_q.push_back({addr + 32'(4 * k), w});
        end
        push_byte(8'h00 - s + (bad ? 8'h01 : 8'h00));
        exp_tx_q.push_back((bad || n == 0) ? NAK_BYTE : ACK_BYTE);
    endtask

    task automatic wait_tx(input int target, input int budget);
        int k;
        k = 0;
        while (tx_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("resp_wait", 64'(tx_cnt >= target), 64'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int t0, w0;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, w0, k;
        rst = 1'b1;
        mem_ready_i = 1'b0;
        uart_data_i = 8'h00;
        idle(3);
        check_eq("reset_outputs",
                 {uart_read_o, uart_write_o, mem_we_o, busy_o, done_o, err_o, dbg_state_o,
                  uart_data_o, mem_addr_o[15:0], mem_data_o[31:0]}, 64'd0);
        rst = 1'b0;
        idle(2);
        check_eq("idle_busy", 64'(busy_o), 64'd0);

        // nominal single word, hand-checked checksum B7
        push_byte(8'hA5);
        push_byte(8'h00); push_byte(8'h10); push_byte(8'h00); push_byte(8'h00);
        push_byte(8'h01);
        push_byte(8'hEF); push_byte(8'hBE); push_byte(8'hAD); push_byte(8'hDE);
        push_byte(8'hB7);
        exp_q.push_back({32'h0000_1000, 32'hDEAD_BEEF});
        exp_tx_q.push_back(ACK_BYTE);
        wait_tx(1, 400);
        idle(2);
        check_eq("post_resp_busy", 64'(busy_o), 64'd0);
        check_eq("post_resp_state", 64'(dbg_state_o), 64'(ST_HUNT));

        // three words with a 3-cycle memory stall each
        mem_stall = 3;
        push_pkt(32'h0000_0100, 3, 32'h0302_0100, 1'b0);
        wait_tx(2, 600);
        mem_stall = 0;
        check_eq("stall_stable", 64'(stable_err), 64'd0);
        check_eq("stall_writes", 64'(we_acc), 64'd4);

        // bad checksum followed at once by a good packet
        push_pkt(32'h0000_0200, 1, 32'hCAFE_F00D, 1'b1);
        push_pkt(32'h0000_0300, 1, 32'h0BAD_C0DE, 1'b0);
        wait_tx(4, 800);

        // leading garbage, then a valid packet: exactly one response
        push_byte(8'h00); push_byte(8'hFF); push_byte(8'h5A);
        push_pkt(32'h0000_2000, 1, 32'h1234_5678, 1'b0);
        wait_tx(5, 400);
        idle(20);
        check_eq("garbage_single_resp", 64'(tx_cnt), 64'd5);

        // zero-length packet: NAK, no memory write
        w0 = we_acc;
        push_pkt(32'h0000_0000, 0, 32'h0, 1'b0);
        wait_tx(6, 400);
        idle(10);
        check_eq("len0_no_write", 64'(we_acc), 64'(w0));

        // RX empty toggling under the reader
        rx_tog = 1'b1;
        push_pkt(32'h0000_3000, 2, 32'hA5A5_0001, 1'b0);
        wait_tx(7, 1200);
        rx_tog = 1'b0;
        check_eq("no_pop_when_empty", 64'(rd_viol), 64'd0);

        // TX full holds off the response for 10 cycles
        tx_full = 1'b1;
        push_pkt(32'h0000_4000, 1, 32'h0000_00AA, 1'b0);
        k = 0;
        while (dbg_state_o != ST_RESP && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq("reach_resp", 64'(dbg_state_o), 64'(ST_RESP));
        check_eq("busy_in_resp", 64'(busy_o), 64'd1);
        t0 = tx_cnt;
        idle(10);
        check_eq("txfull_holdoff", 64'(tx_cnt), 64'(t0));
        tx_full = 1'b0;
        wait_tx(8, 20);
        idle(5);
        check_eq("txfull_single_push", 64'(tx_cnt), 64'd8);

        // reset in the middle of a data word
        push_byte(8'hA5);
        push_byte(8'h00); push_byte(8'h50); push_byte(8'h00); push_byte(8'h00);
        push_byte(8'h02); push_byte(8'h11); push_byte(8'h22);
        k = 0;
        while (rx_rp != rx_wp && k < 100) begin
            @(negedge clk);
            k++;
        end
        idle(4);
        check_eq("pre_reset_state", 64'(dbg_state_o), 64'(ST_DATA));
        rst = 1'b1;
        @(negedge clk);
        check_eq("midpkt_reset_outputs",
                 {uart_read_o, uart_write_o, mem_we_o, busy_o, done_o, err_o, dbg_state_o,
                  uart_data_o, mem_addr_o[15:0], mem_data_o[31:0]}, 64'd0);
        rst = 1'b0;
        idle(20);
        check_eq("reset_no_resp", 64'(tx_cnt), 64'd8);
        push_pkt(32'h0000_6000, 1, 32'h5555_AAAA, 1'b0);
        wait_tx(9, 400);

`ifdef UART_LOADER_TIMEOUT_EN
        // stream stops after A1: NAK after the timeout
        push_byte(8'hA5); push_byte(8'h00); push_byte(8'h10);
        exp_tx_q.push_back(NAK_BYTE);
        idle(TMO / 2);
        check_eq("tmo_not_early", 64'(tx_cnt), 64'd9);
        wait_tx(10, TMO + 50);
`endif

        idle(5);
        check_eq("writes_outstanding", 64'(exp_q.size()), 64'd0);
        check_eq("resp_outstanding", 64'(exp_tx_q.size()), 64'd0);
        check_eq("done_matches_push", 64'(pulse_err), 64'd0);
        check_eq("rx_empty_respected", 64'(rd_viol), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
